// File: rtl/race_control.sv
// race_control: race sequencer feeding the lap timer's start/stop/lap_finished inputs.
// Runs the pre-race countdown, validates in-order checkpoint crossings, counts laps
// and ends the race after NUM_LAPS laps.
// Optional feature macro: RACE_CONTROL_FALSE_START_EN (checkpoint during countdown = false start).
module race_control #(
    parameter int NUM_CHECKPOINTS = 4,
    parameter int NUM_LAPS        = 3,
    parameter int COUNTDOWN_STEPS = 3,
    parameter int TICK_DIV        = 65000000
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       race_req,
    input  logic       abort,
    input  logic       cp_valid,
    input  logic [2:0] cp_id,
    output logic       start,
    output logic       stop,
    output logic       lap_finished,
    output logic [3:0] countdown,
    output logic [3:0] lap_count,
    output logic       race_active,
    output logic       race_done,
    output logic       cp_error,
    output logic       false_start
);

    // A single-cycle tick period would give $clog2 of 0, so keep at least one bit.
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
    localparam logic [3:0] CD_START = 4'(COUNTDOWN_STEPS);
    localparam logic [3:0] LAST_LAP = 4'(NUM_LAPS - 1);
    localparam logic [2:0] LAST_CP  = 3'(NUM_CHECKPOINTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        COUNTDOWN,
        RACING,
        STOPPING,
        FINISHED
    } state_t;

    state_t            state, state_next;
    logic [TICK_W-1:0] tick, tick_next;
    logic [2:0]        expected, expected_next;
    logic [2:0]        last_id, last_id_next;
    logic [3:0]        countdown_next, lap_count_next;
    logic              start_next, stop_next, lap_finished_next, cp_error_next;
    logic              race_active_next, race_done_next, false_start_next;

    // Register state and every output so the lap timer only sees clean, glitch-free pulses.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tick         <= '0;
            expected     <= 3'd1;
            last_id      <= 3'd0;
            countdown    <= 4'd0;
            lap_count    <= 4'd0;
            start        <= 1'b0;
            stop         <= 1'b0;
            lap_finished <= 1'b0;
            cp_error     <= 1'b0;
            race_active  <= 1'b0;
            race_done    <= 1'b0;
            false_start  <= 1'b0;
        end else begin
            state        <= state_next;
            tick         <= tick_next;
            expected     <= expected_next;
            last_id      <= last_id_next;
            countdown    <= countdown_next;
            lap_count    <= lap_count_next;
            start        <= start_next;
            stop         <= stop_next;
            lap_finished <= lap_finished_next;
            cp_error     <= cp_error_next;
            race_active  <= race_active_next;
            race_done    <= race_done_next;
            false_start  <= false_start_next;
        end
    end

    // Next-state and next-output logic; pulses default low so each lasts exactly one cycle.
    always_comb begin
        state_next        = state;
        tick_next         = tick;
        expected_next     = expected;
        last_id_next      = last_id;
        countdown_next    = countdown;
        lap_count_next    = lap_count;
        start_next        = 1'b0;
        stop_next         = 1'b0;
        lap_finished_next = 1'b0;
        cp_error_next     = 1'b0;
`ifdef RACE_CONTROL_FALSE_START_EN
        false_start_next  = false_start;
`else
        false_start_next  = 1'b0;
`endif

        case (state)
            IDLE, FINISHED: begin
                if (race_req) begin
                    state_next       = COUNTDOWN;
                    countdown_next   = CD_START;
                    tick_next        = '0;
                    lap_count_next   = 4'd0;
                    expected_next    = 3'd1;
                    false_start_next = 1'b0;
                end
            end

            COUNTDOWN: begin
                if (abort) begin
                    state_next     = IDLE;
                    countdown_next = 4'd0;
                end
`ifdef RACE_CONTROL_FALSE_START_EN
                else if (cp_valid && (cp_id != 3'd0)) begin
                    state_next       = IDLE;
                    countdown_next   = 4'd0;
                    false_start_next = 1'b1;
                end
`endif
                else if (tick == TICK_MAX) begin
                    tick_next = '0;
                    if (countdown == 4'd1) begin
                        countdown_next = 4'd0;
                        state_next     = RACING;
                        start_next     = 1'b1;
                    end else begin
                        countdown_next = countdown - 4'd1;
                    end
                end else begin
                    tick_next = tick + 1'b1;
                end
            end

            RACING: begin
                if (abort) begin
                    state_next = IDLE;
                    stop_next  = 1'b1;
                end else if (cp_valid) begin
                    if (cp_id == expected) begin
                        last_id_next = cp_id;
                        if (expected == 3'd0) begin
                            lap_finished_next = 1'b1;
                            lap_count_next    = lap_count + 4'd1;
                            expected_next     = 3'd1;
                            // Final lap: stop must follow one cycle later, never alongside lap_finished.
                            if (lap_count == LAST_LAP) begin
                                state_next = STOPPING;
                            end
                        end else if (expected == LAST_CP) begin
                            expected_next = 3'd0;
                        end else begin
                            expected_next = expected + 3'd1;
                        end
                    end else if (cp_id != last_id) begin
                        cp_error_next = 1'b1;
                    end
                end
            end

            STOPPING: begin
                stop_next  = 1'b1;
                state_next = FINISHED;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        race_active_next = (state_next == RACING);
        race_done_next   = (state_next == FINISHED);
    end

endmodule

// File: tb/tb_race_control.sv
// tb_race_control: directed, table-driven bench for race_control
// (TICK_DIV=10, COUNTDOWN_STEPS=3, NUM_CHECKPOINTS=4, NUM_LAPS=2).
module tb_race_control;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       race_req = 1'b0;
    logic       abort = 1'b0;
    logic       cp_valid = 1'b0;
    logic [2:0] cp_id = 3'd0;
    logic       start, stop, lap_finished, race_active, race_done, cp_error, false_start;
    logic [3:0] countdown, lap_count;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       race_req;
        logic       abort;
        logic       cp_valid;
        logic [2:0] cp_id;
        logic       start;
        logic       stop;
        logic       lap_finished;
        logic       cp_error;
        logic       race_active;
        logic       race_done;
        logic [3:0] lap_count;
    } vec_t;

    vec_t vecs[$];

    race_control #(
        .NUM_CHECKPOINTS(4),
        .NUM_LAPS(2),
        .COUNTDOWN_STEPS(3),
        .TICK_DIV(10)
    ) dut (
        .pclk(pclk),
        .rst_n(rst_n),
        .race_req(race_req),
        .abort(abort),
        .cp_valid(cp_valid),
        .cp_id(cp_id),
        .start(start),
        .stop(stop),
        .lap_finished(lap_finished),
        .countdown(countdown),
        .lap_count(lap_count),
        .race_active(race_active),
        .race_done(race_done),
        .cp_error(cp_error),
        .false_start(false_start)
    );

    // 10 ns clock period
    always #5 pclk = ~pclk;

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] simulation timed out");
    end

    function automatic vec_t mk(input logic rq, input logic ab, input logic v, input logic [2:0] id,
                                input logic st, input logic sp, input logic lf, input logic ce,
                                input logic ra, input logic rd, input logic [3:0] lc);
        vec_t r;
        r.race_req = rq; r.abort = ab; r.cp_valid = v; r.cp_id = id;
        r.start = st; r.stop = sp; r.lap_finished = lf; r.cp_error = ce;
        r.race_active = ra; r.race_done = rd; r.lap_count = lc;
        return r;
    endfunction

    // Called at a falling edge: drive one cycle of inputs, return at the next falling edge
    task automatic apply_stimulus(input logic rq, input logic ab, input logic v, input logic [2:0] id);
        race_req = rq;
        abort    = ab;
        cp_valid = v;
        cp_id    = id;
        @(negedge pclk);
    endtask

    task automatic check_output(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic check_zero(input string tag);
        check_output({tag, ".start"}, int'(start), 0);
        check_output({tag, ".stop"}, int'(stop), 0);
        check_output({tag, ".lap_finished"}, int'(lap_finished), 0);
        check_output({tag, ".cp_error"}, int'(cp_error), 0);
        check_output({tag, ".race_active"}, int'(race_active), 0);
        check_output({tag, ".race_done"}, int'(race_done), 0);
        check_output({tag, ".false_start"}, int'(false_start), 0);
        check_output({tag, ".countdown"}, int'(countdown), 0);
        check_output({tag, ".lap_count"}, int'(lap_count), 0);
    endtask

    // race_req in cycle 0; countdown 3/2/1 over cycles 1-10/11-20/21-30; start at cycle 31.
    // A cp_id 1 strobe is injected in cycle 'inject' (0 = none).
    task automatic run_countdown(input string tag, input int inject);
        int exp_cd;
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0);
        for (int c = 1; c <= 31; c++) begin
            exp_cd = (c <= 10) ? 3 : (c <= 20) ? 2 : (c <= 30) ? 1 : 0;
            check_output($sformatf("%s.countdown@%0d", tag, c), int'(countdown), exp_cd);
            check_output($sformatf("%s.start@%0d", tag, c), int'(start), (c == 31) ? 1 : 0);
            check_output($sformatf("%s.race_active@%0d", tag, c), int'(race_active), (c == 31) ? 1 : 0);
            check_output($sformatf("%s.lap_count@%0d", tag, c), int'(lap_count), 0);
            check_output($sformatf("%s.race_done@%0d", tag, c), int'(race_done), 0);
            check_output($sformatf("%s.false_start@%0d", tag, c), int'(false_start), 0);
            if (c < 31) begin
                apply_stimulus(1'b0, 1'b0, (c == inject) ? 1'b1 : 1'b0, 3'd1);
            end
        end
    endtask

    initial begin
        int starts;

        // Racing-phase vectors, applied right after the start pulse of the first race.
        //                 req ab v  id     st sp lf ce ra rd lc
        vecs.push_back(mk(0, 0, 0, 3'd0,  0, 0, 0, 0, 1, 0, 4'd0)); // start is one cycle
        vecs.push_back(mk(0, 0, 1, 3'd2,  0, 0, 0, 1, 1, 0, 4'd0)); // cp 2 first: error
        vecs.push_back(mk(0, 0, 0, 3'd0,  0, 0, 0, 0, 1, 0, 4'd0)); // error is one cycle
        vecs.push_back(mk(0, 0, 1, 3'd1,  0, 0, 0, 0, 1, 0, 4'd0));
        vecs.push_back(mk(0, 0, 1, 3'd1,  0, 0, 0, 0, 1, 0, 4'd0)); // re-trigger ignored
        vecs.push_back(mk(0, 0, 1, 3'd2,  0, 0, 0, 0, 1, 0, 4'd0));
        vecs.push_back(mk(0, 0, 1, 3'd3,  0, 0, 0, 0, 1, 0, 4'd0));
        vecs.push_back(mk(0, 0, 1, 3'd0,  0, 0, 1, 0, 1, 0, 4'd1)); // lap 1
        vecs.push_back(mk(0, 0, 0, 3'd0,  0, 0, 0, 0, 1, 0, 4'd1));
        vecs.push_back(mk(1, 0, 0, 3'd0,  0, 0, 0, 0, 1, 0, 4'd1)); // race_req ignored
        vecs.push_back(mk(0, 0, 1, 3'd0,  0, 0, 0, 0, 1, 0, 4'd1)); // finish re-trigger ignored
        vecs.push_back(mk(0, 0, 1, 3'd5,  0, 0, 0, 1, 1, 0, 4'd1)); // out-of-range id
        vecs.push_back(mk(0, 0, 1, 3'd1,  0, 0, 0, 0, 1, 0, 4'd1));
        vecs.push_back(mk(0, 0, 1, 3'd2,  0, 0, 0, 0, 1, 0, 4'd1));
        vecs.push_back(mk(0, 0, 1, 3'd3,  0, 0, 0, 0, 1, 0, 4'd1));
        vecs.push_back(mk(0, 0, 1, 3'd0,  0, 0, 1, 0, 0, 0, 4'd2)); // final lap -> STOPPING
        vecs.push_back(mk(0, 1, 1, 3'd1,  0, 1, 0, 0, 0, 1, 4'd2)); // stop next cycle, inputs ignored
        vecs.push_back(mk(0, 0, 0, 3'd0,  0, 0, 0, 0, 0, 1, 4'd2));
        vecs.push_back(mk(0, 0, 1, 3'd1,  0, 0, 0, 0, 0, 1, 4'd2)); // FINISHED ignores cp
        vecs.push_back(mk(0, 1, 0, 3'd0,  0, 0, 0, 0, 0, 1, 4'd2)); // FINISHED ignores abort

        $display("[TB] reset state");
        repeat (2) @(negedge pclk);
        check_zero("reset");
        rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b1, 3'd1);
        check_zero("idle_cp");

        $display("[TB] race 1: countdown then vector table");
        run_countdown("cd1", 0);
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].race_req, vecs[i].abort, vecs[i].cp_valid, vecs[i].cp_id);
            check_output($sformatf("v%0d.start", i), int'(start), int'(vecs[i].start));
            check_output($sformatf("v%0d.stop", i), int'(stop), int'(vecs[i].stop));
            check_output($sformatf("v%0d.lap_finished", i), int'(lap_finished), int'(vecs[i].lap_finished));
            check_output($sformatf("v%0d.cp_error", i), int'(cp_error), int'(vecs[i].cp_error));
            check_output($sformatf("v%0d.race_active", i), int'(race_active), int'(vecs[i].race_active));
            check_output($sformatf("v%0d.race_done", i), int'(race_done), int'(vecs[i].race_done));
            check_output($sformatf("v%0d.lap_count", i), int'(lap_count), int'(vecs[i].lap_count));
            check_output($sformatf("v%0d.countdown", i), int'(countdown), 0);
        end

        $display("[TB] race 2: abort on the final checkpoint");
        run_countdown("cd2", 0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 3'd1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 3'd2);
        apply_stimulus(1'b0, 1'b0, 1'b1, 3'd3);
        apply_stimulus(1'b0, 1'b0, 1'b1, 3'd0);
        check_output("ab.lap1_finished", int'(lap_finished), 1);
        check_output("ab.lap1_count", int'(lap_count), 1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 3'd1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 3'd2);
        apply_stimulus(1'b0, 1'b0, 1'b1, 3'd3);
        check_output("ab.pre_cp_error", int'(cp_error), 0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 3'd0);
        check_output("ab.stop", int'(stop), 1);
        check_output("ab.lap_finished", int'(lap_finished), 0);
        check_output("ab.race_active", int'(race_active), 0);
        check_output("ab.race_done", int'(race_done), 0);
        check_output("ab.lap_count", int'(lap_count), 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 3'd0);
        check_output("ab.stop_one_cycle", int'(stop), 0);
        check_output("ab.no_late_lap", int'(lap_finished), 0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 3'd1);
        check_output("ab.idle_race_active", int'(race_active), 0);
        check_output("ab.idle_cp_error", int'(cp_error), 0);

        $display("[TB] asynchronous reset mid-countdown");
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0);
        check_output("rst.countdown_loaded", int'(countdown), 3);
        check_output("rst.lap_count_cleared", int'(lap_count), 0);
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 3'd0);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge pclk);
        rst_n = 1'b1;

        $display("[TB] abort during countdown");
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0);
        check_output("abcd.countdown_loaded", int'(countdown), 3);
        repeat (4) apply_stimulus(1'b0, 1'b0, 1'b0, 3'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 3'd0);
        check_output("abcd.countdown", int'(countdown), 0);
        check_output("abcd.stop", int'(stop), 0);
        starts = 0;
        repeat (35) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 3'd0);
            if (start) starts++;
        end
        check_output("abcd.start_count", starts, 0);
        check_output("abcd.race_active", int'(race_active), 0);

`ifdef RACE_CONTROL_FALSE_START_EN
        $display("[TB] false start");
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0);
        check_output("fs.countdown_loaded", int'(countdown), 3);
        repeat (4) apply_stimulus(1'b0, 1'b0, 1'b0, 3'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 3'd1);
        check_output("fs.flag", int'(false_start), 1);
        check_output("fs.countdown", int'(countdown), 0);
        starts = 0;
        repeat (35) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 3'd0);
            if (start) starts++;
        end
        check_output("fs.start_count", starts, 0);
        check_output("fs.flag_sticky", int'(false_start), 1);
        run_countdown("fs_retry", 0);
`else
        $display("[TB] checkpoint during countdown is ignored");
        run_countdown("cp_in_cd", 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
